mem_port_arbiter: RTL

Two-requester arbiter that shares one single-port data BRAM between the CPU load/store path and the VGA frame fetcher. Each cycle it grants the port to at most one requester, stalls the CPU while it waits, and routes the BRAM's one-cycle-latency read data back to the owner. The fetcher has priority, and a starvation counter bounds the CPU's wait. It sits between the CPU memory/IO mux and the data memory, in the divided CPU clock domain.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between the CPU load/store path and the VGA fetcher (fetcher has priority).
// Latency: grant is combinational (0 cycles); rvalid/rdata appear in the cycle after the read grant.
// Backpressure: a losing CPU is stalled; a starvation counter forces a CPU win after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_t            rd_owner;
    logic [3:0]        starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;

    always_comb begin
        cpu_gnt = 1'b0;
        vga_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && vga_req) begin
                if (starve_cnt >= STARVE_LIM) cpu_gnt = 1'b1;
                else                          vga_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                vga_gnt = vga_req;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | vga_gnt;
        mem_we    = cpu_gnt & cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt)      mem_addr = cpu_addr;
        else if (vga_gnt) mem_addr = vga_addr;
        if (mem_en)       mem_wdata = cpu_wdata;
    end

    assign cpu_stall  = ~reset & cpu_req & ~cpu_gnt;

    // Returns are gated by reset so a read in flight at reset is discarded.
    assign cpu_rvalid = ~reset & (rd_owner == OWN_CPU);
    assign vga_rvalid = ~reset & (rd_owner == OWN_VGA);
    assign cpu_rdata  = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
    assign vga_rdata  = reset ? '0 : (vga_rvalid ? mem_rdata : vga_rdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= 4'd0;
            rd_owner    <= OWN_NONE;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            if (cpu_req && !cpu_gnt)
                starve_cnt <= (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;

            if (cpu_gnt && !cpu_we) rd_owner <= OWN_CPU;
            else if (vga_gnt)       rd_owner <= OWN_VGA;
            else                    rd_owner <= OWN_NONE;

            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (vga_rvalid) vga_rdata_q <= mem_rdata;
        end
    end

endmodule
